uart_tx_param: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises one data word per request: start bit, DATA_BITS data bits LSB first, optional parity bit, and a configurable stop period. Timing comes from the shared oversampling baud-tick generator (i_tick). Sits between the TX FIFO/ALU result path and the board TX pin, and exposes a ready/start handshake plus a one-cycle done pulse.

---
 rtl/uart_tx_param.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, stop period.
// Bit timing comes from an external oversampling tick (OVS_TICKS per bit,
// STOP_TICKS for the stop period).
// Optional feature: define UART_TX_PARITY_EN to insert the PARITY state.
module uart_tx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVS_TICKS  = 16,
  parameter int unsigned STOP_TICKS = 16
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_tx_start,
  input  logic                 i_parity_odd,
  output logic                 o_ready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_tx
);

  // Tick counter must hold the larger of the two period lengths minus one.
  localparam int unsigned TICK_MAX = (OVS_TICKS > STOP_TICKS) ? OVS_TICKS : STOP_TICKS;
  localparam int unsigned TICK_W   = (TICK_MAX > 2) ? $clog2(TICK_MAX) : 1;
  localparam int unsigned BIT_W    = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] OVS_LAST  = TICK_W'(OVS_TICKS - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(STOP_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_n;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [TICK_W-1:0]    w_tick_cnt_n;
  logic [TICK_W-1:0]    w_tick_inc;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BIT_W-1:0]     w_bit_cnt_n;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_n;
  logic                 r_tx;
  logic                 w_tx_n;
  logic                 r_ready;
  logic                 r_busy;
  logic                 w_done_c;
  logic                 w_ovs_end;
  logic                 w_stop_end;
  logic                 w_bit_last;

`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
  logic                 w_parity_n;
`else
  // Parity select has no function in this build.
  logic                 w_unused_parity_odd;
  assign w_unused_parity_odd = i_parity_odd;
`endif

  // Period-end detection: counter only moves on tick cycles.
  assign w_tick_inc = r_tick_cnt + TICK_W'(1);
  assign w_ovs_end  = i_tick & (r_tick_cnt == OVS_LAST);
  assign w_stop_end = i_tick & (r_tick_cnt == STOP_LAST);
  assign w_bit_last = (r_bit_cnt == BIT_LAST);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_tick_cnt <= w_tick_cnt_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_shift    <= w_shift_n;
      r_tx       <= w_tx_n;
      r_ready    <= (w_state_n == S_IDLE);
      r_busy     <= (w_state_n != S_IDLE);
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity bit computed once from the accepted word and odd/even select.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_n;
    end
  end
`endif

  // Next-state, counters, shift register and next line value.
  always_comb begin
    w_state_n    = r_state;
    w_tick_cnt_n = r_tick_cnt;
    w_bit_cnt_n  = r_bit_cnt;
    w_shift_n    = r_shift;
    w_tx_n       = r_tx;
    w_done_c     = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_n   = r_parity;
`endif

    case (r_state)
      S_IDLE: begin
        w_tx_n = 1'b1;
        // A tick coinciding with the accept is deliberately not counted.
        if (i_tx_start) begin
          w_shift_n    = i_data;
          w_tick_cnt_n = '0;
          w_bit_cnt_n  = '0;
          w_tx_n       = 1'b0;
          w_state_n    = S_START;
`ifdef UART_TX_PARITY_EN
          w_parity_n   = (^i_data) ^ i_parity_odd;
`endif
        end
      end

      S_START: begin
        if (i_tick) begin
          if (w_ovs_end) begin
            w_tick_cnt_n = '0;
            w_tx_n       = r_shift[0];
            w_state_n    = S_DATA;
          end else begin
            w_tick_cnt_n = w_tick_inc;
          end
        end
      end

      S_DATA: begin
        if (i_tick) begin
          if (w_ovs_end) begin
            w_tick_cnt_n = '0;
            if (!w_bit_last) begin
              w_shift_n   = {1'b0, r_shift[DATA_BITS-1:1]};
              w_bit_cnt_n = r_bit_cnt + BIT_W'(1);
              w_tx_n      = r_shift[1];
            end else begin
`ifdef UART_TX_PARITY_EN
              w_tx_n    = r_parity;
              w_state_n = S_PARITY;
`else
              w_tx_n    = 1'b1;
              w_state_n = S_STOP;
`endif
            end
          end else begin
            w_tick_cnt_n = w_tick_inc;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (i_tick) begin
          if (w_ovs_end) begin
            w_tick_cnt_n = '0;
            w_tx_n       = 1'b1;
            w_state_n    = S_STOP;
          end else begin
            w_tick_cnt_n = w_tick_inc;
          end
        end
      end
`endif

      S_STOP: begin
        w_tx_n = 1'b1;
        if (i_tick) begin
          if (w_stop_end) begin
            w_tick_cnt_n = '0;
            w_bit_cnt_n  = '0;
            w_done_c     = 1'b1;
            w_state_n    = S_IDLE;
          end else begin
            w_tick_cnt_n = w_tick_inc;
          end
        end
      end

      default: begin
        // Unreachable encodings fall back to an idle line.
        w_state_n    = S_IDLE;
        w_tick_cnt_n = '0;
        w_bit_cnt_n  = '0;
        w_tx_n       = 1'b1;
      end
    endcase
  end

  // Done marks the final stop tick; a reset on that cycle suppresses it.
  assign o_done  = w_done_c & ~i_reset;
  assign o_tx    = r_tx;
  assign o_ready = r_ready;
  assign o_busy  = r_busy;

endmodule
